aes_inv_key_sched: RTL and testbench
====================================

# aes_inv_key_sched

Iterative AES-128 inverse key schedule. It takes the final (round-10) round key and walks the schedule backwards, producing round keys 10 down to 0 one per handshake. It is the decryption-side counterpart of the forward combinational key-generation step. It feeds the inverse-cipher datapath, which consumes round keys in reverse order without storing all eleven.

## Interface
Parameters:
- NR, 10, number of AES rounds. Only 10 (AES-128) is supported; any other value is an elaboration error.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- start_i  input  1  one-cycle request; samples key_i when in IDLE
- key_i  input  128  round-10 key, word w0 at [127:96] … w3 at [31:0]
- rk_o  output  128  current round key, same word ordering as key_i
- rk_round_o  output  4  round index of rk_o, 10 down to 0
- rk_valid_o  output  1  rk_o / rk_round_o are valid
- rk_ready_i  input  1  consumer accepts rk_o this cycle
- busy_o  output  1  high from start acceptance until the final handshake
- done_o  output  1  one-cycle pulse after round 0 is accepted

## Operation
- States: IDLE, EMIT.
- **IDLE:**
  - busy_o=0 and rk_valid_o=0.
  - start_i=1 loads key_i into the key register, sets round=10 and moves to EMIT.
- **EMIT:** rk_valid_o=1 and busy_o=1.
  - **Handshake (rk_valid_o & rk_ready_i) with round>0:** register the inverse step and decrement round. Stay in EMIT.
  - **Handshake with round=0:** go to IDLE and pulse done_o on the following cycle.
  - **No handshake:** rk_o and rk_round_o are held bit-stable.
- Inverse step from round r (words w0..w3) to round r-1 (words v0..v3):
  - v3 = w3^w2
  - v2 = w2^w1
  - v1 = w1^w0
  - v0 = w0 ^ SubWord(RotWord(v3)) ^ {RCON[r-1],24'h0}
- RotWord is a left byte rotate: the bytes of v3 are taken in order [23:16],[15:8],[7:0],[31:24].
- RCON[0..9] = 01,02,04,08,10,20,40,80,1b,36. For example, the step out of round 10 uses 36 and the step out of round 1 uses 01.
- start_i is ignored when not in IDLE. This includes the done_o cycle: the FSM is already IDLE then, so start_i is accepted in that cycle.
- All XOR arithmetic is 32-bit with no carries. rk_round_o never wraps below 0.

## Timing
- Reset values: all outputs are 0 and the state is IDLE. Reset asserted mid-sequence aborts at the next edge, with no done_o pulse.
- start_i accepted at edge N: rk_valid_o=1, rk_round_o=10 and rk_o=key_i are all visible after edge N.
- The inverse step is single-cycle combinational from the key register, so rk_valid_o stays high between consecutive keys.
- Throughput is one round key per cycle with rk_ready_i tied high. A full sequence is 11 cycles of valid, then done_o 1 cycle later.
- Latency from the round-r handshake edge to the round-(r-1) key is 1 cycle.
- rk_ready_i while rk_valid_o=0 has no effect.
- done_o and rk_valid_o are never high in the same cycle.

## Structure
- The shared package aes_pkg holds:
  - AES_NR = 10
  - the rcon lookup function (index 0..9 → byte, default 00)
  - the state enum (IDLE, EMIT)
  - a 32-bit word typedef
- Sub-module aes_sub_word: purely combinational, 32-bit in and 32-bit out, made of four S-box byte lookups. It is instantiated once.
- The remaining logic (FSM, round counter, key register, XOR network) lives in aes_inv_key_sched.

## Test plan
- **FIPS-197 vector:**
  - Stimulus: key_i = d014f9a8c9ee2589e13f0cc8b6630ca6, start_i pulse, rk_ready_i=1.
  - Required response: round 10 = key_i, round 9 = ac7766f319fadc2128d12941575c006e, round 1 = a0fafe1788542cb123a339392a6c7605, round 0 = 2b7e151628aed2a6abf7158809cf4f3c, then done_o one cycle after the final handshake.
- **Backpressure:** same vector with rk_ready_i low for 3 cycles on round 9 → rk_o and rk_round_o are held stable, rk_valid_o stays high and the remaining sequence is unchanged.
- **Start while busy:** start_i pulsed with key_i=0 during round 5 → ignored, and the sequence completes with the original keys.
- **Reset mid-sequence:** rst asserted at round 4 → the next cycle has all outputs 0 and no done_o. A subsequent start then runs a full correct sequence.
- **Back-to-back:** start_i asserted during the done_o cycle → accepted, and round 10 of the new key appears on the next cycle.
- **Round-trip:** random round-0 keys are expanded by the forward key-generation step to round 10 and fed back in → round 0 out equals the original key, over 1000 iterations.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, word type, FSM states, RCON and S-box lookups.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [31:0] word_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Forward S-box, indexed by input byte.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Out-of-range indices return 00 so the idle step at round 0 is harmless.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_inv_key_sched_if.sv
// Request/round-key handshake bundle between the inverse key schedule and its consumer.
interface aes_inv_key_sched_if;
  logic         start_i;
  logic [127:0] key_i;
  logic [127:0] rk_o;
  logic [3:0]   rk_round_o;
  logic         rk_valid_o;
  logic         rk_ready_i;
  logic         busy_o;
  logic         done_o;

  modport slave (
    input  start_i, key_i, rk_ready_i,
    output rk_o, rk_round_o, rk_valid_o, busy_o, done_o
  );

  modport master (
    output start_i, key_i, rk_ready_i,
    input  rk_o, rk_round_o, rk_valid_o, busy_o, done_o
  );
endinterface

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box byte substitutions, purely combinational.
module aes_sub_word
  import aes_pkg::*;
(
  input  word_t w_i,
  output word_t w_o
);

  assign w_o = {sbox(w_i[31:24]), sbox(w_i[23:16]), sbox(w_i[15:8]), sbox(w_i[7:0])};

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key schedule: walks from the round-10 key back to round 0,
// presenting one round key per valid/ready handshake.
module aes_inv_key_sched
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_inv_key_sched_if.slave   bus
);

  if (NR != AES_NR) begin : g_nr_check
    $error("aes_inv_key_sched: only NR=10 (AES-128) is supported");
  end

  state_e       state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] key_q,   key_d;
  logic         done_q,  done_d;

  word_t w0_s, w1_s, w2_s, w3_s;
  word_t v0_s, v1_s, v2_s, v3_s;
  word_t rot_s, sub_s;
  logic  hs_s;

  assign w0_s = key_q[127:96];
  assign w1_s = key_q[95:64];
  assign w2_s = key_q[63:32];
  assign w3_s = key_q[31:0];

  // Undo the forward chaining first; v3 then feeds the g-function for v0.
  assign v3_s  = w3_s ^ w2_s;
  assign v2_s  = w2_s ^ w1_s;
  assign v1_s  = w1_s ^ w0_s;
  assign rot_s = {v3_s[23:0], v3_s[31:24]};

  aes_sub_word u_sub_word (
    .w_i (rot_s),
    .w_o (sub_s)
  );

  assign v0_s = w0_s ^ sub_s ^ {rcon(round_q - 4'd1), 24'h000000};

  assign hs_s = (state_q == EMIT) && bus.rk_ready_i;

  // Next-state, round counter and key register update.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    key_d   = key_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          key_d   = bus.key_i;
          round_d = 4'(NR);
          state_d = EMIT;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (hs_s) begin
          if (round_q != 4'd0) begin
            key_d   = {v0_s, v1_s, v2_s, v3_s};
            round_d = round_q - 4'd1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      key_q   <= 128'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      key_q   <= key_d;
      done_q  <= done_d;
    end
  end

  assign bus.rk_o       = key_q;
  assign bus.rk_round_o = round_q;
  assign bus.rk_valid_o = (state_q == EMIT);
  assign bus.busy_o     = (state_q == EMIT);
  assign bus.done_o     = done_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Scoreboard bench for aes_inv_key_sched: stimulus pushes expected round keys,
// a negedge monitor pops and compares on every handshake.
module tb_aes_inv_key_sched;
  import aes_pkg::*;

  typedef struct packed {
    logic [3:0]   rnd;
    logic [127:0] key;
  } exp_t;

  localparam logic [127:0] FIPS_RK0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_inv_key_sched_if bus ();

  aes_inv_key_sched #(.NR(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] rc_tb [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [31:0] sw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Forward expansion: produce round r from round r-1.
  function automatic logic [127:0] fwd(input logic [127:0] k, input int r);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sw({k[23:0], k[31:24]}) ^ {rc_tb[r-1], 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Push rounds 10..0 for a sequence; returns the round-10 key to drive.
  task automatic push_seq(input logic [127:0] rk0, input bit fips, output logic [127:0] rk10);
    logic [127:0] rk [11];
    rk[0] = rk0;
    for (int i = 1; i <= 10; i++) rk[i] = fwd(rk[i-1], i);
    if (fips) begin
      rk[10] = FIPS_RK10;
      rk[9]  = FIPS_RK9;
      rk[1]  = FIPS_RK1;
      rk[0]  = FIPS_RK0;
    end
    for (int r = 10; r >= 0; r--) sb.push_back({4'(r), rk[r]});
    rk10 = rk[10];
  endtask

  // Called at posedge+1; leaves after the accepting edge.
  task automatic start_seq(input logic [127:0] rk0, input bit fips);
    logic [127:0] k10;
    push_seq(rk0, fips, k10);
    bus.key_i   = k10;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.done_o === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: done_o not seen within 100 cycles (got 0, required 1)", name);
    end
  endtask

  task automatic wait_round(input logic [3:0] r, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.rk_valid_o === 1'b1 && bus.rk_round_o === r) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: round %0d never presented (last round %0d)", name, r, bus.rk_round_o);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (bus.rk_o !== 128'd0 || bus.rk_round_o !== 4'd0 || bus.rk_valid_o !== 1'b0 ||
        bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL %s: rk=%h round=%0d valid=%b busy=%b done=%b, required all zero",
               name, bus.rk_o, bus.rk_round_o, bus.rk_valid_o, bus.busy_o, bus.done_o);
    end
  endtask

  // Monitor: handshakes pop the scoreboard; stalls must hold outputs; done timing.
  bit           exp_done = 1'b0;
  bit           stall    = 1'b0;
  logic [127:0] hold_rk;
  logic [3:0]   hold_rnd;
  always @(negedge clk) begin
    exp_t e;
    if (rst !== 1'b0) begin
      exp_done = 1'b0;
      stall    = 1'b0;
    end else begin
      checks++;
      if (bus.done_o !== exp_done || (bus.done_o && bus.rk_valid_o) || bus.busy_o !== bus.rk_valid_o) begin
        errors++;
        $display("FAIL ctrl: done=%b valid=%b busy=%b, required done=%b, no done with valid, busy==valid",
                 bus.done_o, bus.rk_valid_o, bus.busy_o, exp_done);
      end
      if (stall) begin
        checks++;
        if (bus.rk_o !== hold_rk || bus.rk_round_o !== hold_rnd || bus.rk_valid_o !== 1'b1) begin
          errors++;
          $display("FAIL hold: rk=%h round=%0d valid=%b, required rk=%h round=%0d valid=1",
                   bus.rk_o, bus.rk_round_o, bus.rk_valid_o, hold_rk, hold_rnd);
        end
      end
      exp_done = 1'b0;
      stall    = 1'b0;
      if (bus.rk_valid_o === 1'b1 && bus.rk_ready_i === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected: round %0d key %h with empty scoreboard", bus.rk_round_o, bus.rk_o);
        end else begin
          e = sb.pop_front();
          if (bus.rk_round_o !== e.rnd || bus.rk_o !== e.key) begin
            errors++;
            $display("FAIL rk: got round %0d key %h, required round %0d key %h",
                     bus.rk_round_o, bus.rk_o, e.rnd, e.key);
          end
          if (e.rnd == 4'd0) exp_done = 1'b1;
        end
      end else if (bus.rk_valid_o === 1'b1) begin
        stall    = 1'b1;
        hold_rk  = bus.rk_o;
        hold_rnd = bus.rk_round_o;
      end
    end
  end

  initial begin
    logic [127:0] rk0;
    rst            = 1'b1;
    bus.start_i    = 1'b0;
    bus.key_i      = 128'd0;
    bus.rk_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Plain FIPS-197 sequence.
    start_seq(FIPS_RK0, 1'b1);
    wait_done("fips");

    // Backpressure on round 9 for three cycles.
    start_seq(FIPS_RK0, 1'b1);
    wait_round(4'd9, "bp_round9");
    bus.rk_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.rk_ready_i = 1'b1;
    wait_done("backpressure");

    // Start with a zero key while busy must be ignored.
    start_seq(FIPS_RK0, 1'b1);
    wait_round(4'd5, "busy_round5");
    bus.key_i   = 128'd0;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    wait_done("start_busy");

    // Reset at round 4 aborts; a fresh sequence then runs normally.
    start_seq(FIPS_RK0, 1'b1);
    wait_round(4'd4, "rst_round4");
    rst = 1'b1;
    @(posedge clk); #1;
    check_zero("reset_mid");
    rst = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    start_seq(FIPS_RK0, 1'b1);
    wait_done("after_reset");

    // Back-to-back: start in the done cycle, new key's round 10 must follow.
    rk0 = {$urandom, $urandom, $urandom, $urandom};
    start_seq(rk0, 1'b0);
    wait_done("b2b_first");
    start_seq(FIPS_RK0, 1'b1);
    wait_done("b2b_second");

    // Round-trip over random round-0 keys.
    for (int it = 0; it < 1000; it++) begin
      rk0 = {$urandom, $urandom, $urandom, $urandom};
      start_seq(rk0, 1'b0);
      wait_done("roundtrip");
    end

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected round keys never presented, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
